egress_voq: RTL

EGRESS_VOQ -- requirements
Module: egress_voq

---
 rtl/egress_voq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/egress_voq.sv
// egress_voq: per-egress-port virtual output queue of frame start pointers.
//
// Holds up to DEPTH frame start pointers (SRAM block indices) in arrival order.
// The head entry is offered to the memory read controller with a valid/ready
// handshake. An enqueue that finds the queue full, with no pop in the same
// cycle, is rejected. The cycle after a rejection, drop_req_o pulses with the
// rejected pointer so the block chain can be freed.
//
// Ports:
//   clk               switch clock
//   rst_n             asynchronous active-low reset
//   voq_write_req_i   enqueue request, one frame per asserted cycle
//   voq_start_ptr_i   start pointer of the frame to enqueue
//   deq_valid_o       head entry available
//   deq_ptr_o         head start pointer
//   deq_ready_i       read controller accepts the head entry
//   count_o           current occupancy
//   full_o            occupancy equals DEPTH
//   drop_req_o        one-cycle pulse after a rejected enqueue
//   drop_ptr_o        pointer of the rejected frame, valid with drop_req_o
//   drop_cnt_o        saturating count of rejections
//
// Build option: define EGRESS_VOQ_DROP_STATS_EN to enable the 16-bit
// saturating rejection counter on drop_cnt_o; otherwise drop_cnt_o is tied to 0.

module egress_voq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       voq_write_req_i,
  input  logic [ADDR_W-1:0]          voq_start_ptr_i,
  output logic                       deq_valid_o,
  output logic [ADDR_W-1:0]          deq_ptr_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       drop_req_o,
  output logic [ADDR_W-1:0]          drop_ptr_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              drop_req_q, drop_req_d;
  logic [ADDR_W-1:0] drop_ptr_q, drop_ptr_d;

  logic pop, push, reject, is_full, is_empty;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == DepthC);
    pop      = ~is_empty & deq_ready_i;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    push     = voq_write_req_i & (~is_full | pop);
    reject   = voq_write_req_i & is_full & ~pop;

    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    count_d    = count_q;
    drop_req_d = reject;
    drop_ptr_d = drop_ptr_q;

    // Power-of-two depth: index increment wraps DEPTH-1 -> 0 naturally.
    if (pop)  rd_idx_d = rd_idx_q + IdxW'(1);
    if (push) wr_idx_d = wr_idx_q + IdxW'(1);

    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);

    if (reject) drop_ptr_d = voq_start_ptr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      count_q    <= '0;
      drop_req_q <= 1'b0;
      drop_ptr_q <= '0;
    end else begin
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      count_q    <= count_d;
      drop_req_q <= drop_req_d;
      drop_ptr_q <= drop_ptr_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx_q] <= voq_start_ptr_i;
  end

`ifdef EGRESS_VOQ_DROP_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (reject && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 16'h0000;
`endif

  assign deq_valid_o = (count_q != '0);
  assign deq_ptr_o   = mem_q[rd_idx_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == DepthC);
  assign drop_req_o  = drop_req_q;
  assign drop_ptr_o  = drop_ptr_q;

endmodule
